uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
// Shares one UART transmit byte path between P_NUM_REQ independent frame sources.
// Arbitrates round-robin at frame boundaries and holds the grant until the frame's last byte.
// Optionally prefixes each frame with a channel-ID header byte.
// Drives the user side of the TX DMA FIFO; i_tx_ready is that FIFO's not-full.
// PARAMETERS
// P_NUM_REQ   4     number of requesters, 2..8
// P_HDR_EN    1     1: emit header byte {4'hA, 1'b0, id[2:0]} before each frame
// P_TIMEOUT   255   idle cycles of granted source mid-frame before abort, 1..255
// PORTS
// i_clk        in   1            system clock
// i_rst        in   1            async active-high reset
// i_req_valid  in   P_NUM_REQ    per-source byte valid
// i_req_data   in   8*P_NUM_REQ  per-source byte; source n at [8n+7:8n]
// i_req_last   in   P_NUM_REQ    per-source last byte of frame, qualified by valid
// o_req_ready  out  P_NUM_REQ    per-source byte accepted when valid&ready
// o_tx_valid   out  1            byte to TX FIFO valid (registered)
// o_tx_data    out  8            byte to TX FIFO (registered)
// i_tx_ready   in   1            downstream accepts byte when valid&ready
// o_grant_id   out  3            current/last granted source index
// o_busy       out  1            1 in any state other than IDLE
// o_timeout    out  1            one-cycle pulse on frame abort
// BEHAVIOUR
// - Reset: state IDLE, rr pointer 0, o_req_ready 0, o_tx_valid 0, o_tx_data 0,
//   o_grant_id 0, o_busy 0, o_timeout 0, timeout counter 0. Reset mid-frame drops the frame.
// - Output register: loads when empty (!o_tx_valid) or when o_tx_valid&i_tx_ready.
//   Data is held stable while o_tx_valid&!i_tx_ready.
// - "slot" = !o_tx_valid | i_tx_ready.
// - IDLE: if any i_req_valid, grant = first valid index searching upward from the rr pointer
//   with wrap; register grant into o_grant_id; go HDR (P_HDR_EN=1) or DATA. Else stay.
// - HDR: when slot, load header byte, o_tx_valid<=1, go DATA.
//   No o_req_ready is asserted in HDR.
// - DATA: o_req_ready[g] = slot (combinational); all other ready bits 0.
//   - On valid[g]&ready[g]: load i_req_data[g], o_tx_valid<=1, timeout counter <=0.
//   - If i_req_last[g] also set: rr pointer <= g+1 mod P_NUM_REQ, go IDLE.
// - Timeout (DATA only): counter increments each cycle !i_req_valid[g].
//   Backpressure cycles (valid but !slot) do not count.
//   When count reaches P_TIMEOUT: o_timeout pulse, rr pointer <= g+1, go IDLE.
//   Any byte already in the output register is still delivered.
// - When slot and no new byte is loaded, o_tx_valid <= 0.
// - Latency: source valid in IDLE at cycle k -> grant at k+1 -> header valid at k+2
//   -> first data byte accepted at k+2 or later. With P_HDR_EN=0, first data is accepted at k+1.
// - Frames are never interleaved. A valid from a non-granted source waits, ready 0.
// - Single-byte frame (valid&last on first byte) is legal: header + 1 byte.
// - Simultaneous requests are resolved by the rr pointer only.
//   A source that just finished has lowest priority next round.
// TESTING
// 1. Src1 sends 3-byte frame 11,22,33(last), ready=1 -> tx: A1,11,22,33 back-to-back; o_busy drops after 33.
// 2. Src0..3 all request 2-byte frames simultaneously, ptr=0 -> frames in order 0,1,2,3, never interleaved.
// 3. ready held 0 for 5 cycles mid-frame -> o_tx_data stable, no byte lost or duplicated, o_req_ready low.
// 4. Src2 stalls after byte 1, P_TIMEOUT=8 -> o_timeout pulse after 8 idle cycles; next grant goes to src3.
// 5. P_HDR_EN=0, single-byte frame 5A from src0 -> exactly one tx byte 5A, grant returns to IDLE.
// 6. Assert i_rst during DATA -> all outputs 0 immediately; next frame starts with fresh header.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, frame-atomic sharing of one TX byte path between P_NUM_REQ sources,
// with an optional channel-ID header byte in front of each frame and a mid-frame stall abort.
module uart_tx_arbiter #(
  parameter int P_NUM_REQ = 4,
  parameter bit P_HDR_EN  = 1'b1,
  parameter int P_TIMEOUT = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [P_NUM_REQ-1:0]   i_req_valid,
  input  logic [8*P_NUM_REQ-1:0] i_req_data,
  input  logic [P_NUM_REQ-1:0]   i_req_last,
  output logic [P_NUM_REQ-1:0]   o_req_ready,
  output logic                   o_tx_valid,
  output logic [7:0]             o_tx_data,
  input  logic                   i_tx_ready,
  output logic [2:0]             o_grant_id,
  output logic                   o_busy,
  output logic                   o_timeout
);
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
  state_t state, state_nxt;
  logic [7:0] valid_x, last_x, cnt, g_data;
  logic [63:0] data_x;
  logic [2:0] ptr, pick;
  logic slot, any, accept, expire, done;

  function automatic logic [2:0] wrap(input logic [2:0] b, input int o);
    int s;
    s = int'(b) + o;
    return 3'(s >= P_NUM_REQ ? s - P_NUM_REQ : s);
  endfunction

  // Source vectors widened to the full 3-bit id space so the grant can index them directly.
  assign valid_x = 8'(i_req_valid);
  assign last_x = 8'(i_req_last);
  assign data_x = 64'(i_req_data);
  assign g_data = data_x[{o_grant_id, 3'b000} +: 8];
  assign slot = !o_tx_valid || i_tx_ready;
  assign any = |i_req_valid;
  assign accept = state == DATA && valid_x[o_grant_id] && slot;
  assign expire = state == DATA && !valid_x[o_grant_id] && cnt == 8'(P_TIMEOUT - 1);
  assign done = (accept && last_x[o_grant_id]) || expire;

  always_comb begin
    pick = ptr;
    for (int i = P_NUM_REQ - 1; i >= 0; i--)
      if (valid_x[wrap(ptr, i)]) pick = wrap(ptr, i);
  end

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state <= IDLE;
    else state <= state_nxt;

  always_comb begin
    state_nxt = state;
    if (state == IDLE && any) state_nxt = DATA;
    if (state == IDLE && any && P_HDR_EN) state_nxt = HDR;
    if (state == HDR && slot) state_nxt = DATA;
    if (done) state_nxt = IDLE;
  end

  always_comb begin
    o_busy = state != IDLE;
    o_req_ready = (state == DATA && slot) ? {{(P_NUM_REQ-1){1'b0}}, 1'b1} << o_grant_id : '0;
  end

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      ptr <= '0;
      o_grant_id <= '0;
      o_tx_valid <= 1'b0;
      o_tx_data <= '0;
      cnt <= '0;
      o_timeout <= 1'b0;
    end else begin
      if (state == IDLE && any) o_grant_id <= pick;
      if (state == HDR && slot) begin
        o_tx_valid <= 1'b1;
        o_tx_data <= {4'hA, 1'b0, o_grant_id};
      end else if (accept) begin
        o_tx_valid <= 1'b1;
        o_tx_data <= g_data;
      end else if (slot) o_tx_valid <= 1'b0;
      // Only cycles with the granted source silent count toward the abort; backpressure holds.
      cnt <= (state != DATA || accept || expire) ? 8'd0 : valid_x[o_grant_id] ? cnt : cnt + 8'd1;
      if (done) ptr <= wrap(o_grant_id, 1);
      o_timeout <= expire;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus randomized traffic on a header and a headerless
// arbiter sharing one stimulus, each compared cycle by cycle with a behavioural model.
module tb_uart_tx_arbiter;
  localparam int N = 4, TMO = 8;
  logic clk = 1'b0, rst = 1'b1, tx_ready = 1'b1;
  logic [N-1:0] req_valid = '0, req_last = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0] rdy [2];
  logic tv [2], bsy [2], tmo [2];
  logic [7:0] td [2];
  logic [2:0] gid [2];
  bit m_busy [2], m_hdr [2], m_vld [2], m_to [2];
  logic [7:0] m_dat [2];
  int m_g [2], m_ptr [2], m_cnt [2], acc [2];
  logic [8:0] q [N][$];
  bit pres [N];
  logic [7:0] cap0 [$], cap1 [$], e [$], held;
  int gate_pct = 100, drv = 0, n_vec = 0, n_err = 0, n_to = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.P_NUM_REQ(N), .P_HDR_EN(1'b1), .P_TIMEOUT(TMO)) u0 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
    .i_req_last(req_last), .o_req_ready(rdy[0]), .o_tx_valid(tv[0]), .o_tx_data(td[0]),
    .i_tx_ready(tx_ready), .o_grant_id(gid[0]), .o_busy(bsy[0]), .o_timeout(tmo[0]));

  uart_tx_arbiter #(.P_NUM_REQ(N), .P_HDR_EN(1'b0), .P_TIMEOUT(TMO)) u1 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
    .i_req_last(req_last), .o_req_ready(rdy[1]), .o_tx_valid(tv[1]), .o_tx_data(td[1]),
    .i_tx_ready(tx_ready), .o_grant_id(gid[1]), .o_busy(bsy[1]), .o_timeout(tmo[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_hdr[i] = 0; m_vld[i] = 0; m_to[i] = 0;
      m_dat[i] = 8'h00; m_g[i] = 0; m_ptr[i] = 0; m_cnt[i] = 0; acc[i] = -1;
    end
  endtask

  // One clock of the arbiter's rules: who owns the path, what lands in the output byte, and when.
  task automatic model_step(input int i, input bit hdr_en);
    bit slot, load;
    int k;
    slot = !m_vld[i] || tx_ready;
    load = 0; m_to[i] = 0; acc[i] = -1;
    if (!m_busy[i]) begin
      if (req_valid != 0) begin
        k = 0;
        while (!req_valid[(m_ptr[i] + k) % N]) k++;
        m_g[i] = (m_ptr[i] + k) % N;
        m_busy[i] = 1; m_hdr[i] = hdr_en;
      end
    end else if (m_hdr[i]) begin
      if (slot) begin load = 1; m_dat[i] = 8'hA0 + 8'(m_g[i]); m_hdr[i] = 0; end
    end else if (req_valid[m_g[i]]) begin
      if (slot) begin
        load = 1; m_dat[i] = req_data[8*m_g[i] +: 8]; m_cnt[i] = 0; acc[i] = m_g[i];
        if (req_last[m_g[i]]) begin m_busy[i] = 0; m_ptr[i] = (m_g[i] + 1) % N; end
      end
    end else begin
      m_cnt[i]++;
      if (m_cnt[i] == TMO) begin
        m_to[i] = 1; m_cnt[i] = 0; m_busy[i] = 0; m_ptr[i] = (m_g[i] + 1) % N;
      end
    end
    if (load) m_vld[i] = 1;
    else if (slot) m_vld[i] = 0;
  endtask

  task automatic drive();
    for (int n = 0; n < N; n++) begin
      if (!pres[n] && q[n].size() > 0 && $urandom_range(99) < gate_pct) pres[n] = 1;
      req_valid[n] = pres[n];
      req_data[8*n +: 8] = pres[n] ? q[n][0][7:0] : 8'($urandom);
      req_last[n] = pres[n] ? q[n][0][8] : 1'($urandom);
    end
  endtask

  task automatic tick();
    logic [N-1:0] er;
    #1;
    for (int i = 0; i < 2; i++) begin
      er = (m_busy[i] && !m_hdr[i] && (!m_vld[i] || tx_ready)) ? 4'(1 << m_g[i]) : 4'd0;
      check($sformatf("ready%0d", i), 32'(rdy[i]), 32'(er));
      check($sformatf("tx_valid%0d", i), 32'(tv[i]), 32'(m_vld[i]));
      check($sformatf("tx_data%0d", i), 32'(td[i]), 32'(m_dat[i]));
      check($sformatf("grant%0d", i), 32'(gid[i]), 32'(m_g[i]));
      check($sformatf("busy%0d", i), 32'(bsy[i]), 32'(m_busy[i]));
      check($sformatf("timeout%0d", i), 32'(tmo[i]), 32'(m_to[i]));
    end
    if (tv[0] && tx_ready) cap0.push_back(td[0]);
    if (tv[1] && tx_ready) cap1.push_back(td[1]);
    if (tmo[0]) n_to++;
    @(posedge clk);
    model_step(0, 1'b1);
    model_step(1, 1'b0);
    @(negedge clk);
    if (acc[drv] >= 0 && pres[acc[drv]]) begin
      void'(q[acc[drv]].pop_front());
      pres[acc[drv]] = 0;
    end
    drive();
  endtask

  function automatic bit all_idle();
    bit r;
    r = !m_busy[0] && !m_busy[1] && !m_vld[0] && !m_vld[1];
    for (int n = 0; n < N; n++) r = r && q[n].size() == 0 && !pres[n];
    return r;
  endfunction

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (t < 300 && !all_idle()) begin tick(); t++; end
    check({tag, "_drain"}, 32'(t < 300), 32'd1);
    tick();
  endtask

  task automatic push(input int n, input logic [7:0] b, input bit last);
    q[n].push_back({last, b});
  endtask

  task automatic expect_stream(input string tag, input logic [7:0] got [$], input logic [7:0] exp [$]);
    check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int k = 0; k < exp.size() && k < got.size(); k++)
      check($sformatf("%s[%0d]", tag, k), 32'(got[k]), 32'(exp[k]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_ready", 32'(rdy[i]), 0);
      check("rst_tx_valid", 32'(tv[i]), 0);
      check("rst_tx_data", 32'(td[i]), 0);
      check("rst_grant", 32'(gid[i]), 0);
      check("rst_busy", 32'(bsy[i]), 0);
      check("rst_timeout", 32'(tmo[i]), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    drive();
    // All four sources request two-byte frames together from pointer 0.
    cap0.delete();
    for (int n = 0; n < N; n++) begin
      push(n, 8'(16*n + 1), 1'b0);
      push(n, 8'(16*n + 2), 1'b1);
    end
    drive();
    drain("t2");
    e = '{8'hA0, 8'h01, 8'h02, 8'hA1, 8'h11, 8'h12, 8'hA2, 8'h21, 8'h22, 8'hA3, 8'h31, 8'h32};
    expect_stream("t2", cap0, e);
    // Single source, three-byte frame.
    cap0.delete();
    push(1, 8'h11, 1'b0); push(1, 8'h22, 1'b0); push(1, 8'h33, 1'b1);
    drive();
    drain("t1");
    e = '{8'hA1, 8'h11, 8'h22, 8'h33};
    expect_stream("t1", cap0, e);
    // Downstream stall for five cycles mid-frame.
    cap0.delete();
    push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b0); push(0, 8'h43, 1'b0); push(0, 8'h44, 1'b1);
    drive();
    repeat (4) tick();
    tx_ready = 1'b0;
    held = td[0];
    repeat (5) begin
      #1;
      check("t3_ready_low", 32'(rdy[0]), 0);
      check("t3_hold", 32'(td[0]), 32'(held));
      tick();
    end
    tx_ready = 1'b1;
    drain("t3");
    e = '{8'hA0, 8'h41, 8'h42, 8'h43, 8'h44};
    expect_stream("t3", cap0, e);
    // Source 2 goes silent mid-frame; source 3 is waiting.
    cap0.delete();
    n_to = 0;
    push(2, 8'hB1, 1'b0);
    push(3, 8'hC1, 1'b0); push(3, 8'hC2, 1'b1);
    drive();
    drain("t4");
    e = '{8'hA2, 8'hB1, 8'hA3, 8'hC1, 8'hC2};
    expect_stream("t4", cap0, e);
    check("t4_timeouts", 32'(n_to), 1);
    // Headerless arbiter, single-byte frame; sources follow its handshake.
    drv = 1;
    cap1.delete();
    push(0, 8'h5A, 1'b1);
    drive();
    drain("t5");
    e = '{8'h5A};
    expect_stream("t5", cap1, e);
    check("t5_busy", 32'(bsy[1]), 0);
    drv = 0;
    // Asynchronous reset in the middle of a frame.
    push(0, 8'h61, 1'b0); push(0, 8'h62, 1'b0); push(0, 8'h63, 1'b0); push(0, 8'h64, 1'b1);
    drive();
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    check("t6_ready", 32'(rdy[0]), 0);
    check("t6_tx_valid", 32'(tv[0]), 0);
    check("t6_tx_data", 32'(td[0]), 0);
    check("t6_grant", 32'(gid[0]), 0);
    check("t6_busy", 32'(bsy[0]), 0);
    check("t6_timeout", 32'(tmo[0]), 0);
    model_reset();
    for (int n = 0; n < N; n++) begin q[n].delete(); pres[n] = 0; end
    drive();
    @(negedge clk);
    rst = 1'b0;
    cap0.delete();
    push(1, 8'h77, 1'b1);
    drive();
    drain("t6");
    e = '{8'hA1, 8'h77};
    expect_stream("t6", cap0, e);
    // Random traffic with gaps, stalls and occasional aborts.
    gate_pct = 60;
    for (int c = 0; c < 2000; c++) begin
      for (int n = 0; n < N; n++)
        if (q[n].size() == 0 && $urandom_range(7) == 0) begin
          int len;
          len = $urandom_range(4, 1);
          for (int k = 0; k < len; k++) push(n, 8'($urandom), k == len - 1);
        end
      tx_ready = $urandom_range(3) != 0;
      tick();
    end
    gate_pct = 100;
    tx_ready = 1'b1;
    drain("rand");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
